// File: rtl/nvme_cmd_engine.sv
// NVMe-style command engine: host word parser, command FIFO,
// executor with local memory, response and error/interrupt logic.
module nvme_cmd_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              irq_req,
    input  logic              irq_ack,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = 4 + ADDR_W;
    localparam int EW = CW + DATA_W;
    localparam logic [PW:0] FULL_LVL = (PW+1)'(QDEPTH);

    localparam logic [3:0] OP_RD  = 4'h0;
    localparam logic [3:0] OP_WR  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_INV = 4'hF;

    typedef enum logic {P_CMD, P_WDATA} pstate_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP, ERR} estate_t;

    pstate_t pstate;
    estate_t estate;

    logic [CW-1:0]     cmd_lat;
    logic [EW-1:0]     q_mem [QDEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       level;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              full;
    logic              empty;
    logic              rx_fire;
    logic              push;
    logic              pop;
    logic [3:0]        rx_op;
    logic [CW-1:0]     rx_cmd;
    logic [EW-1:0]     push_word;
    logic [EW-1:0]     head;
    logic [DATA_W-1:0] status_w;

    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign rx_ready = !full;
    assign rx_fire  = rx_valid && rx_ready;
    assign rx_op    = rx_data[DATA_W-1 -: 4];
    assign rx_cmd   = {rx_op, rx_data[ADDR_W-1:0]};

    // Writes need a second word; everything else enqueues at once
    assign push = rx_fire &&
                  ((pstate == P_WDATA) || (rx_op != OP_WR));
    assign push_word = (pstate == P_WDATA) ?
                       {cmd_lat, rx_data} :
                       {rx_cmd, {DATA_W{1'b0}}};

    assign head     = q_mem[rd_ptr];
    assign pop      = (estate == IDLE) && !empty;
    assign busy     = !empty || (estate != IDLE);
    assign status_w = DATA_W'({err_count, 8'(level)});

    // Receive parser: pairs a write command with its data word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pstate  <= P_CMD;
            cmd_lat <= '0;
        end else if (rx_fire) begin
            if (pstate == P_WDATA) begin
                pstate <= P_CMD;
            end else if (rx_op == OP_WR) begin
                pstate  <= P_WDATA;
                cmd_lat <= rx_cmd;
            end
        end
    end

    // Queue pointers and level; pointers wrap since depth is 2**PW
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Queue storage, contents need no reset
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= push_word;
    end

    // Engine FSM with registered response and error outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estate    <= IDLE;
            cmd_op    <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            irq_req   <= 1'b0;
            err_count <= '0;
        end else begin
            if (irq_ack) irq_req <= 1'b0;
            unique case (estate)
                IDLE: begin
                    if (pop) begin
                        cmd_op   <= head[EW-1 -: 4];
                        cmd_addr <= head[DATA_W +: ADDR_W];
                        cmd_data <= head[DATA_W-1:0];
                        estate   <= EXEC;
                    end
                end
                EXEC: begin
                    unique case (1'b1)
                        (cmd_op == OP_RD): begin
                            tx_data  <= mem[cmd_addr];
                            tx_valid <= 1'b1;
                            estate   <= RESP;
                        end
                        (cmd_op == OP_ST): begin
                            tx_data  <= status_w;
                            tx_valid <= 1'b1;
                            estate   <= RESP;
                        end
                        (cmd_op == OP_INV): estate <= ERR;
                        default:            estate <= IDLE;
                    endcase
                end
                RESP: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        estate   <= IDLE;
                    end
                end
                ERR: begin
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                    irq_req <= 1'b1;
                    estate  <= IDLE;
                end
            endcase
        end
    end

    // Local memory write port, contents survive reset
    always_ff @(posedge clk) begin
        if (estate == EXEC && cmd_op == OP_WR) begin
            mem[cmd_addr] <= cmd_data;
        end
    end

endmodule

// File: doc/nvme_cmd_engine.md
NVME_CMD_ENGINE -- requirements
Module: nvme_cmd_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of the host data and command word.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning the memory address width; the memory holds 2**ADDR_W words; ADDR_W SHALL be no greater than DATA_W-4.
REQ-003 The block SHALL have parameter QDEPTH, default 4, meaning the command queue depth in entries; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have the following ports, clock and reset first (name  direction  width  meaning):
  clk  in  1  single clock; all logic on its rising edge
  reset_n  in  1  asynchronous, active-low reset
  rx_valid  in  1  host word valid
  rx_ready  out  1  block can accept a host word
  rx_data  in  DATA_W  host word
  tx_valid  out  1  response word valid
  tx_ready  in  1  host accepts the response word
  tx_data  out  DATA_W  response word
  irq_req  out  1  error interrupt request
  irq_ack  in  1  interrupt acknowledge
  err_count  out  8  saturating count of invalid commands
  busy  out  1  queue non-empty or engine not IDLE
REQ-005 A host word SHALL transfer only in a cycle where rx_valid and rx_ready are both 1; a response word SHALL transfer only in a cycle where tx_valid and tx_ready are both 1.

Function
REQ-006 The command word format SHALL be: bits [DATA_W-1:DATA_W-4] are the opcode, and bits [ADDR_W-1:0] are the address.
REQ-007 Opcodes SHALL be: 0 read, 1 write, 2 status, F invalid; all other opcodes are NOP.
REQ-008 The receive parser SHALL be a two-state FSM, P_CMD and P_WDATA.
  - P_CMD: an accepted command word with opcode 1 moves the FSM to P_WDATA and latches the word; any other opcode pushes {cmd, 0} into the queue in the same cycle.
  - P_WDATA: the next accepted word pushes {latched cmd, word} into the queue and returns the FSM to P_CMD.
REQ-009 rx_ready SHALL equal 1 exactly when the queue is not full, and it SHALL NOT depend on a pop in the same cycle.
REQ-010 The queue SHALL be a FIFO of QDEPTH entries with wrapping pointers and a level counter of width log2(QDEPTH)+1; pushes and pops in the same cycle leave the level unchanged.
REQ-011 The engine FSM SHALL have the states IDLE, EXEC, RESP and ERR.
  - IDLE: when the queue is not empty, pop the head entry into the command register and go to EXEC.
REQ-012 EXEC SHALL perform the following per opcode:
  - read: issue a synchronous memory read and go to RESP.
  - write: write the data to memory[addr] and go to IDLE.
  - status: load the status word and go to RESP.
  - F: go to ERR.
  - NOP: go to IDLE.
REQ-013 RESP SHALL hold tx_valid=1 with a stable tx_data until tx_ready=1, then go to IDLE; tx_data SHALL be the memory word for a read, and {zero-extended err_count[7:0], queue level} for a status command.
REQ-014 A read command SHALL produce tx_valid=1 in the second cycle after its pop cycle when tx_ready is held high.
REQ-015 ERR SHALL last one cycle: it increments err_count, saturating at 255; sets irq_req; and goes to IDLE.
REQ-016 irq_req SHALL be cleared by irq_ack=1; when irq_ack and ERR occur in the same cycle, irq_req SHALL end the cycle at 1.
REQ-017 Commands SHALL execute strictly in arrival order, so a read following a write to the same address returns the written data.
REQ-018 A write with address bits above ADDR_W that are nonzero SHALL ignore those upper bits.

Reset
REQ-019 When reset_n=0, the block SHALL asynchronously set: both FSMs to P_CMD/IDLE, queue pointers and level to 0, tx_valid=0, tx_data=0, irq_req=0, err_count=0, busy=0; rx_ready SHALL follow as 1.
REQ-020 Reset asserted mid-command SHALL discard all queued and in-flight commands, including a half-received write.
REQ-021 Memory contents SHALL NOT be reset.

Verification
REQ-022 The bench SHALL cover this write-then-read scenario: words 0x1005, 0xBEEF, then 0x0005 with tx_ready=1 -> one response with tx_data=0xBEEF; busy returns to 0.
REQ-023 The bench SHALL cover this backpressure scenario: tx_ready=0, then 5 read commands with QDEPTH=4 -> rx_ready falls to 0 after queue full; tx_data held stable; all 5 responses delivered in order once tx_ready=1.
REQ-024 The bench SHALL cover this invalid-command scenario: command 0xF000 -> irq_req=1 and err_count=1; irq_ack pulse -> irq_req=0; no tx_valid.
REQ-025 The bench SHALL cover this saturation scenario: 300 commands of 0xF000 -> err_count=255; status command 0x2000 -> tx_data[15:8]=0xFF.
REQ-026 The bench SHALL cover this simultaneous-event scenario: irq_ack=1 in the same cycle as ERR -> irq_req=1 afterwards.
REQ-027 The bench SHALL cover this reset-mid-write scenario: 0x1003 accepted, then reset_n pulse, then 0x0003 -> memory[3] unchanged by the discarded write; the parser is in P_CMD after reset.
